// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencer and the instruction decoder:
// state, instruction class, PC source and exception code encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IF      = 3'd1,
        S_ID      = 3'd2,
        S_EX      = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_MD_WAIT = 3'd6,
        S_EXC     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_MULDIV  = 3'd5,
        CLS_MTHILO  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } inst_class_e;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'd0,
        EXC_ILLEGAL     = 2'd1,
        EXC_IF_TIMEOUT  = 2'd2,
        EXC_MEM_TIMEOUT = 2'd3
    } exc_code_e;

    typedef struct packed {
        logic    instram_req;
        logic    ir_wen;
        logic    dataram_req;
        logic    dataram_wen;
        logic    md_start;
        logic    rf_wen;
        logic    hilo_wen;
        logic    pc_wen;
        pc_sel_e pc_sel;
        logic    retire;
        logic    exc;
    } ctrl_out_t;

    // States in which the sequencer waits on a RAM ready and the timeout runs.
    function automatic logic is_ram_wait(input state_e s);
        return (s == S_IF) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Performance counters: active-cycle and retired-instruction counts, wrapping.
// Latency: count visible the cycle after the increment qualifier.
// Backpressure: none; the counters just sample the qualifiers every cycle.
`ifdef CTRL_PERF_CNT_EN
module ctrl_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cyc_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (cyc_inc) cyc_d = cyc_q + CNT_W'(1);
        if (ret_inc) ret_d = ret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;

endmodule
`endif

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction sequencer (IF/ID/EX/MEM/WB/MD_WAIT/EXC); counters under CTRL_PERF_CNT_EN.
// Latency: JUMP 2, BRANCH/MTHILO 3, ALU/STORE 4, LOAD 5, MULDIV 3+md cycles from IF entry to retire.
// Backpressure: holds in IF/MEM until RAM ready (bounded by MEM_TIMEOUT) and in MD_WAIT until md_done.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [2:0]       inst_class,
    input  logic             branch_taken,
    input  logic             instram_ready,
    input  logic             dataram_ready,
    input  logic             md_done,
    output logic             instram_req,
    output logic             ir_wen,
    output logic             dataram_req,
    output logic             dataram_wen,
    output logic             md_start,
    output logic             rf_wen,
    output logic             hilo_wen,
    output logic             pc_wen,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic             exc,
    output logic [1:0]       exc_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_e       state_q, state_d;
    inst_class_e  cls_q, cls_d;
    exc_code_e    exc_code_q, exc_code_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W-1:0] to_inc;
    logic         to_hit;
    inst_class_e  cls_in;
    state_e       after_retire;
    ctrl_out_t    ctl;

    assign cls_in       = inst_class_e'(inst_class);
    assign after_retire = run ? S_IF : S_IDLE;
    assign to_inc       = to_q + TO_W'(1);
    assign to_hit       = (MEM_TIMEOUT != 0) && (to_inc == TO_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cls_q      <= CLS_ALU;
            exc_code_q <= EXC_NONE;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            exc_code_q <= exc_code_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        cls_d      = (state_q == S_ID) ? cls_in : cls_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_IF;
            // A ready arriving on the timeout cycle still completes the access.
            S_IF: begin
                if (instram_ready) begin
                    state_d = S_ID;
                end else if (to_hit) begin
                    state_d    = S_EXC;
                    exc_code_d = EXC_IF_TIMEOUT;
                end
            end
            S_ID: begin
                case (cls_in)
                    CLS_ILLEGAL: begin
                        state_d    = S_EXC;
                        exc_code_d = EXC_ILLEGAL;
                    end
                    CLS_JUMP: state_d = after_retire;
                    default:  state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls_q)
                    CLS_ALU:              state_d = S_WB;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    CLS_MULDIV:           state_d = S_MD_WAIT;
                    default:              state_d = after_retire;
                endcase
            end
            S_MEM: begin
                if (dataram_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? S_WB : after_retire;
                end else if (to_hit) begin
                    state_d    = S_EXC;
                    exc_code_d = EXC_MEM_TIMEOUT;
                end
            end
            S_WB:      state_d = after_retire;
            S_MD_WAIT: if (md_done) state_d = after_retire;
            S_EXC:     state_d = S_EXC;
            default:   state_d = S_IDLE;
        endcase
        // Counter restarts whenever a wait state is freshly entered.
        to_d = (is_ram_wait(state_q) && (state_d == state_q)) ? to_inc : '0;
    end

    always_comb begin
        ctl        = '0;
        ctl.pc_sel = PC_SEL_PC4;
        case (state_q)
            S_IF: begin
                ctl.instram_req = 1'b1;
                ctl.ir_wen      = instram_ready;
            end
            S_ID: begin
                if (cls_in == CLS_JUMP) begin
                    ctl.pc_wen = 1'b1;
                    ctl.pc_sel = PC_SEL_JUMP;
                    ctl.retire = 1'b1;
                end
            end
            S_EX: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        ctl.pc_wen = 1'b1;
                        ctl.pc_sel = branch_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
                        ctl.retire = 1'b1;
                    end
                    CLS_MTHILO: begin
                        ctl.hilo_wen = 1'b1;
                        ctl.pc_wen   = 1'b1;
                        ctl.retire   = 1'b1;
                    end
                    CLS_MULDIV: ctl.md_start = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl.dataram_req = 1'b1;
                ctl.dataram_wen = (cls_q == CLS_STORE);
                if (dataram_ready && (cls_q == CLS_STORE)) begin
                    ctl.pc_wen = 1'b1;
                    ctl.retire = 1'b1;
                end
            end
            S_WB: begin
                ctl.rf_wen = 1'b1;
                ctl.pc_wen = 1'b1;
                ctl.retire = 1'b1;
            end
            S_MD_WAIT: begin
                if (md_done) begin
                    ctl.hilo_wen = 1'b1;
                    ctl.pc_wen   = 1'b1;
                    ctl.retire   = 1'b1;
                end
            end
            S_EXC:   ctl.exc = 1'b1;
            default: ;
        endcase
    end

    assign instram_req = ctl.instram_req;
    assign ir_wen      = ctl.ir_wen;
    assign dataram_req = ctl.dataram_req;
    assign dataram_wen = ctl.dataram_wen;
    assign md_start    = ctl.md_start;
    assign rf_wen      = ctl.rf_wen;
    assign hilo_wen    = ctl.hilo_wen;
    assign pc_wen      = ctl.pc_wen;
    assign pc_sel      = ctl.pc_sel;
    assign retire      = ctl.retire;
    assign exc         = ctl.exc;
    assign exc_code    = exc_code_q;
    assign state       = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic cyc_inc;
    assign cyc_inc = (state_q != S_IDLE) && (state_q != S_EXC);

    ctrl_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .cyc_inc     (cyc_inc),
        .ret_inc     (ctl.retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
